// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame FSM state encoding (also used by the receiver),
// the default bit period for the 10 MHz / 115200 baud link and the parity helper.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Small synchronous FIFO with extra-bit pointers; full/empty from pointer compare, no fall-through.
// Writes while full and reads while empty are dropped; count reflects entries held.
module tx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Wr_En,
  input  logic [WIDTH-1:0]       i_Wr_Data,
  input  logic                   i_Rd_En,
  output logic [WIDTH-1:0]       o_Rd_Data,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [AW:0]      r_Wr_Ptr;
  logic [AW:0]      r_Rd_Ptr;
  logic             w_Wr;
  logic             w_Rd;

  assign o_Empty   = (r_Wr_Ptr == r_Rd_Ptr);
  assign o_Full    = (r_Wr_Ptr[AW] != r_Rd_Ptr[AW]) && (r_Wr_Ptr[AW-1:0] == r_Rd_Ptr[AW-1:0]);
  assign o_Count   = r_Wr_Ptr - r_Rd_Ptr;
  assign o_Rd_Data = r_Mem[r_Rd_Ptr[AW-1:0]];
  assign w_Wr      = i_Wr_En && !o_Full;
  assign w_Rd      = i_Rd_En && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
    end else begin
      if (w_Wr) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Rd) r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are valid.
  always_ff @(posedge i_Clock) begin
    if (w_Wr) r_Mem[r_Wr_Ptr[AW-1:0]] <= i_Wr_Data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1 default, LSB first) fed by a byte FIFO; line low one clock after a write
// reaches an idle, empty transmitter. o_Tx_Ready drops while the FIFO is full; outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset_n,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t      r_State, w_State_Next;
  logic [CNT_W-1:0] r_Clk_Cnt, w_Clk_Cnt_Next, w_Cnt_Step;
  logic [2:0]       r_Bit_Idx, w_Bit_Idx_Next;
  logic             r_Stop_Idx, w_Stop_Idx_Next;
  logic [7:0]       r_Shift, w_Shift_Next;
  logic             r_Tx_Serial, w_Serial_Next;
  logic             r_Tx_Active, r_Tx_Done;
  logic             w_Bit_End, w_Pop, w_Fifo_Full, w_Fifo_Empty;
  logic [7:0]       w_Fifo_Dat;

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (i_Tx_DV),
    .i_Wr_Data (i_Tx_Byte),
    .i_Rd_En   (w_Pop),
    .o_Rd_Data (w_Fifo_Dat),
    .o_Full    (w_Fifo_Full),
    .o_Empty   (w_Fifo_Empty),
    .o_Count   (o_Fifo_Count)
  );

  assign o_Tx_Ready  = ~w_Fifo_Full;
  assign o_Tx_Serial = r_Tx_Serial;
  assign o_Tx_Active = r_Tx_Active;
  assign o_Tx_Done   = r_Tx_Done;
  assign w_Bit_End   = (r_Clk_Cnt == CNT_LAST);
  assign w_Cnt_Step  = w_Bit_End ? '0 : r_Clk_Cnt + 1'b1;

  always_comb begin
    w_State_Next    = r_State;
    w_Clk_Cnt_Next  = r_Clk_Cnt;
    w_Bit_Idx_Next  = r_Bit_Idx;
    w_Stop_Idx_Next = r_Stop_Idx;
    w_Shift_Next    = r_Shift;
    w_Pop           = 1'b0;
    case (r_State)
      IDLE: begin
        if (!w_Fifo_Empty) begin
          w_Pop           = 1'b1;
          w_Shift_Next    = w_Fifo_Dat;
          w_Clk_Cnt_Next  = '0;
          w_Bit_Idx_Next  = '0;
          w_Stop_Idx_Next = 1'b0;
          w_State_Next    = START;
        end
      end
      START: begin
        w_Clk_Cnt_Next = w_Cnt_Step;
        if (w_Bit_End) w_State_Next = DATA;
      end
      DATA: begin
        w_Clk_Cnt_Next = w_Cnt_Step;
        if (w_Bit_End) begin
          w_Bit_Idx_Next = r_Bit_Idx + 1'b1;
          if (r_Bit_Idx == 3'd7) w_State_Next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_Clk_Cnt_Next = w_Cnt_Step;
        if (w_Bit_End) w_State_Next = STOP;
      end
      STOP: begin
        w_Clk_Cnt_Next = w_Cnt_Step;
        if (w_Bit_End) begin
          if (r_Stop_Idx == STOP_LAST) w_State_Next = CLEANUP;
          else w_Stop_Idx_Next = 1'b1;
        end
      end
      CLEANUP: w_State_Next = IDLE;
      default: w_State_Next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin itself comes straight off a flop.
  always_comb begin
    w_Serial_Next = 1'b1;
    case (w_State_Next)
      START:   w_Serial_Next = 1'b0;
      DATA:    w_Serial_Next = w_Shift_Next[w_Bit_Idx_Next];
      PARITY:  w_Serial_Next = parity_bit(w_Shift_Next, PARITY_ODD != 0);
      default: w_Serial_Next = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_State     <= IDLE;
      r_Clk_Cnt   <= '0;
      r_Bit_Idx   <= '0;
      r_Stop_Idx  <= 1'b0;
      r_Shift     <= '0;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      r_State     <= w_State_Next;
      r_Clk_Cnt   <= w_Clk_Cnt_Next;
      r_Bit_Idx   <= w_Bit_Idx_Next;
      r_Stop_Idx  <= w_Stop_Idx_Next;
      r_Shift     <= w_Shift_Next;
      r_Tx_Serial <= w_Serial_Next;
      r_Tx_Active <= (w_State_Next == START) || (w_State_Next == DATA) ||
                     (w_State_Next == PARITY) || (w_State_Next == STOP);
      r_Tx_Done   <= (w_State_Next == CLEANUP);
    end
  end

endmodule
